// File: rtl/tensor_transfer_pkg.sv
// Shared types and constants for the tensor transfer controller.
package tensor_transfer_pkg;

    localparam int MATRIX_DIM          = 4;
    localparam int ELEMENTS_PER_BANK   = MATRIX_DIM * MATRIX_DIM;
    localparam int ELEMENT_INDEX_WIDTH = 4;
    localparam int CPU_ADDRESS_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STORE   = 3'd3,
        ST_DONE    = 3'd4
    } transfer_state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } transfer_op_e;

endpackage

// File: rtl/transfer_address_generator.sv
// Address generator: CPU register address (base + k, wrapping at 256)
// and tensor element address {bank, k}.
module transfer_address_generator
    import tensor_transfer_pkg::*;
#(
    parameter int BANK_WIDTH = 2
) (
    input  logic [CPU_ADDRESS_WIDTH-1:0]              base_address,
    input  logic [BANK_WIDTH-1:0]                     bank,
    input  logic [ELEMENT_INDEX_WIDTH-1:0]            element_index,
    output logic [CPU_ADDRESS_WIDTH-1:0]              cpu_address,
    output logic [BANK_WIDTH+ELEMENT_INDEX_WIDTH-1:0] tensor_address
);

    // Combine latched base/bank with the running element index; the 8-bit sum wraps naturally.
    always_comb begin
        cpu_address    = base_address + {4'b0000, element_index};
        tensor_address = {bank, element_index};
    end

endmodule

// File: rtl/tensor_transfer_controller.sv
// Moves one 4x4 tensor bank between the CPU register file and the tensor
// register file, one element per cycle (LOAD: CPU->tensor, STORE: tensor->CPU).
module tensor_transfer_controller
    import tensor_transfer_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int NUMBER_OF_BANKS = 4,
    localparam int BANK_WIDTH     = $clog2(NUMBER_OF_BANKS)
) (
    input  logic                                          clock_in,
    input  logic                                          reset_n_in,
    input  logic                                          start_in,
    input  logic                                          op_in,
    input  logic [CPU_ADDRESS_WIDTH-1:0]                  cpu_base_address_in,
    input  logic [BANK_WIDTH-1:0]                         tensor_bank_in,
    output logic                                          busy_out,
    output logic                                          done_out,
    output logic                                          stall_out,
    output logic [CPU_ADDRESS_WIDTH-1:0]                  cpu_read_address_out,
    input  logic [DATA_WIDTH-1:0]                         cpu_read_data_in,
    output logic                                          cpu_write_enable_out,
    output logic [CPU_ADDRESS_WIDTH-1:0]                  cpu_write_address_out,
    output logic [DATA_WIDTH-1:0]                         cpu_write_data_out,
    output logic                                          tensor_write_enable_out,
    output logic [BANK_WIDTH+ELEMENT_INDEX_WIDTH-1:0]     tensor_write_address_out,
    output logic [DATA_WIDTH-1:0]                         tensor_write_data_out,
    output logic [BANK_WIDTH-1:0]                         tensor_read_bank_out,
    input  logic [ELEMENTS_PER_BANK*DATA_WIDTH-1:0]       tensor_read_data_in
);

    localparam logic [ELEMENT_INDEX_WIDTH-1:0] LAST_INDEX = 4'(ELEMENTS_PER_BANK - 1);

    transfer_state_e                                  state_r;
    transfer_op_e                                     op_r;
    logic [ELEMENT_INDEX_WIDTH-1:0]                   k_r;
    logic [CPU_ADDRESS_WIDTH-1:0]                     base_r;
    logic [BANK_WIDTH-1:0]                            bank_r;
    logic [ELEMENTS_PER_BANK*DATA_WIDTH-1:0]          snapshot_r;
    logic [CPU_ADDRESS_WIDTH-1:0]                     cpu_address_s;
    logic [BANK_WIDTH+ELEMENT_INDEX_WIDTH-1:0]        tensor_address_s;

    // Matrix element at (row, col); row-major, element k occupies bits [DW*k +: DW].
    function automatic logic [DATA_WIDTH-1:0] element_at(
        input logic [ELEMENTS_PER_BANK*DATA_WIDTH-1:0] matrix,
        input logic [1:0]                              row,
        input logic [1:0]                              col
    );
        int idx;
        idx = int'(row) * MATRIX_DIM + int'(col);
        return matrix[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    transfer_address_generator #(
        .BANK_WIDTH (BANK_WIDTH)
    ) u_address_generator (
        .base_address   (base_r),
        .bank           (bank_r),
        .element_index  (k_r),
        .cpu_address    (cpu_address_s),
        .tensor_address (tensor_address_s)
    );

    // Transfer sequencer: accept a request in IDLE, step k through 16 elements, pulse DONE.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_LOAD;
            k_r        <= 4'd0;
            base_r     <= 8'd0;
            bank_r     <= '0;
            snapshot_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        op_r    <= transfer_op_e'(op_in);
                        base_r  <= cpu_base_address_in;
                        bank_r  <= tensor_bank_in;
                        k_r     <= 4'd0;
                        state_r <= (op_in == OP_STORE) ? ST_CAPTURE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    k_r <= k_r + 4'd1;
                    if (k_r == LAST_INDEX) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_CAPTURE: begin
                    snapshot_r <= tensor_read_data_in;
                    k_r        <= 4'd0;
                    state_r    <= ST_STORE;
                end
                ST_STORE: begin
                    k_r <= k_r + 4'd1;
                    if (k_r == LAST_INDEX) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; everything is zero in IDLE and while reset is held.
    always_comb begin
        busy_out                 = 1'b0;
        done_out                 = 1'b0;
        stall_out                = 1'b0;
        cpu_read_address_out     = 8'd0;
        cpu_write_enable_out     = 1'b0;
        cpu_write_address_out    = 8'd0;
        cpu_write_data_out       = '0;
        tensor_write_enable_out  = 1'b0;
        tensor_write_address_out = '0;
        tensor_write_data_out    = '0;
        tensor_read_bank_out     = '0;
        case (state_r)
            ST_IDLE: begin
                busy_out = 1'b0;
            end
            ST_LOAD: begin
                busy_out             = 1'b1;
                tensor_read_bank_out = bank_r;
                cpu_read_address_out = cpu_address_s;
                if (op_r == OP_LOAD) begin
                    tensor_write_enable_out  = 1'b1;
                    tensor_write_address_out = tensor_address_s;
                    tensor_write_data_out    = cpu_read_data_in;
                end else begin
                    tensor_write_enable_out  = 1'b0;
                end
            end
            ST_CAPTURE: begin
                busy_out             = 1'b1;
                stall_out            = 1'b1;
                tensor_read_bank_out = bank_r;
            end
            ST_STORE: begin
                busy_out             = 1'b1;
                stall_out            = 1'b1;
                tensor_read_bank_out = bank_r;
                if (op_r == OP_STORE) begin
                    cpu_write_enable_out  = 1'b1;
                    cpu_write_address_out = cpu_address_s;
                    cpu_write_data_out    = element_at(snapshot_r, k_r[3:2], k_r[1:0]);
                end else begin
                    cpu_write_enable_out  = 1'b0;
                end
            end
            ST_DONE: begin
                busy_out             = 1'b1;
                done_out             = 1'b1;
                tensor_read_bank_out = bank_r;
            end
            default: begin
                busy_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tensor_transfer_controller.sv
// Directed bench for tensor_transfer_controller with CPU/tensor register-file models.
module tb_tensor_transfer_controller;

    logic         clock_in = 1'b0;
    logic         reset_n_in;
    logic         start_in;
    logic         op_in;
    logic [7:0]   cpu_base_address_in;
    logic [1:0]   tensor_bank_in;
    logic         busy_out, done_out, stall_out;
    logic [7:0]   cpu_read_address_out;
    logic [7:0]   cpu_read_data_in;
    logic         cpu_write_enable_out;
    logic [7:0]   cpu_write_address_out, cpu_write_data_out;
    logic         tensor_write_enable_out;
    logic [5:0]   tensor_write_address_out;
    logic [7:0]   tensor_write_data_out;
    logic [1:0]   tensor_read_bank_out;
    logic [127:0] tensor_read_data_in;

    logic [7:0]   cpu_regs   [256];
    logic [7:0]   cpu_wr_mem [256];
    logic [7:0]   tensor_mem [64];
    logic [7:0]   rd_log     [16];
    logic [127:0] tb_banks   [4];

    int tensor_wr_count, cpu_wr_count, stall_count, done_count;
    int errors = 0;
    int checks = 0;
    int n;

    always #5 clock_in = ~clock_in;

    assign cpu_read_data_in    = cpu_regs[cpu_read_address_out];
    assign tensor_read_data_in = tb_banks[tensor_read_bank_out];

    wire [44:0] all_outs = {busy_out, done_out, stall_out, cpu_read_address_out,
                            cpu_write_enable_out, cpu_write_address_out, cpu_write_data_out,
                            tensor_write_enable_out, tensor_write_address_out,
                            tensor_write_data_out, tensor_read_bank_out};

    tensor_transfer_controller dut (
        .clock_in                 (clock_in),
        .reset_n_in               (reset_n_in),
        .start_in                 (start_in),
        .op_in                    (op_in),
        .cpu_base_address_in      (cpu_base_address_in),
        .tensor_bank_in           (tensor_bank_in),
        .busy_out                 (busy_out),
        .done_out                 (done_out),
        .stall_out                (stall_out),
        .cpu_read_address_out     (cpu_read_address_out),
        .cpu_read_data_in         (cpu_read_data_in),
        .cpu_write_enable_out     (cpu_write_enable_out),
        .cpu_write_address_out    (cpu_write_address_out),
        .cpu_write_data_out       (cpu_write_data_out),
        .tensor_write_enable_out  (tensor_write_enable_out),
        .tensor_write_address_out (tensor_write_address_out),
        .tensor_write_data_out    (tensor_write_data_out),
        .tensor_read_bank_out     (tensor_read_bank_out),
        .tensor_read_data_in      (tensor_read_data_in)
    );

    // Register-file models: commit strobed writes at the clock edge and count activity.
    always @(posedge clock_in) begin
        if (tensor_write_enable_out) begin
            tensor_mem[tensor_write_address_out] = tensor_write_data_out;
            if (tensor_wr_count < 16) rd_log[tensor_wr_count] = cpu_read_address_out;
            tensor_wr_count++;
        end
        if (cpu_write_enable_out) begin
            cpu_wr_mem[cpu_write_address_out] = cpu_write_data_out;
            cpu_wr_count++;
        end
        if (stall_out) stall_count++;
        if (done_out)  done_count++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        tensor_wr_count = 0;
        cpu_wr_count    = 0;
        stall_count     = 0;
        done_count      = 0;
    endtask

    // Step clocks until done_out is seen; n counts posedges with the start sample edge as 1.
    task automatic wait_done(input int start_n, output int cnt);
        cnt = start_n;
        while (done_out !== 1'b1 && cnt < 60) begin
            @(posedge clock_in); #1;
            cnt++;
        end
        if (done_out !== 1'b1) cnt = -1;
    endtask

    initial begin
        reset_n_in = 1'b0; start_in = 1'b0; op_in = 1'b0;
        cpu_base_address_in = 8'h00; tensor_bank_in = 2'd0;
        for (int i = 0; i < 256; i++) begin cpu_regs[i] = 8'h00; cpu_wr_mem[i] = 8'h00; end
        for (int i = 0; i < 64; i++) tensor_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) rd_log[i] = 8'h00;
        tb_banks[0] = {16{8'h11}};
        tb_banks[2] = {16{8'h22}};
        tb_banks[3] = {16{8'h33}};
        for (int k = 0; k < 16; k++) tb_banks[1][8*k +: 8] = 8'(8'hA0 + k);
        clear_counters();

        // Reset state
        #12;
        check("reset_outputs", 128'(all_outs), 128'd0);
        @(negedge clock_in); reset_n_in = 1'b1;

        // LOAD base 0x10 into bank 2
        for (int i = 0; i < 16; i++) cpu_regs[8'h10 + i] = 8'(i + 1);
        clear_counters();
        @(negedge clock_in);
        start_in = 1'b1; op_in = 1'b0; cpu_base_address_in = 8'h10; tensor_bank_in = 2'd2;
        @(posedge clock_in); #1; start_in = 1'b0;
        check("load_busy", 128'(busy_out), 128'd1);
        check("load_stall", 128'(stall_out), 128'd0);
        check("load_twe", 128'(tensor_write_enable_out), 128'd1);
        check("load_taddr0", 128'(tensor_write_address_out), 128'd32);
        check("load_raddr0", 128'(cpu_read_address_out), 128'h10);
        check("load_tdata0", 128'(tensor_write_data_out), 128'd1);
        check("load_rbank", 128'(tensor_read_bank_out), 128'd2);
        wait_done(1, n);
        check("load_latency", 128'(n), 128'd17);
        check("load_stall_cycles", 128'(stall_count), 128'd0);
        check("load_write_count", 128'(tensor_wr_count), 128'd16);
        for (int i = 0; i < 16; i++) check($sformatf("load_mem%0d", i), 128'(tensor_mem[32 + i]), 128'(i + 1));
        @(posedge clock_in); #1;
        check("load_idle_busy", 128'(busy_out), 128'd0);
        check("load_done_pulse", 128'(done_out), 128'd0);
        check("idle_rbank", 128'(tensor_read_bank_out), 128'd0);

        // STORE bank 1 to base 0x40, bank contents change after capture
        clear_counters();
        @(negedge clock_in);
        start_in = 1'b1; op_in = 1'b1; cpu_base_address_in = 8'h40; tensor_bank_in = 2'd1;
        @(posedge clock_in); #1; start_in = 1'b0;
        check("capture_stall", 128'(stall_out), 128'd1);
        check("capture_cwe", 128'(cpu_write_enable_out), 128'd0);
        check("capture_twe", 128'(tensor_write_enable_out), 128'd0);
        check("capture_rbank", 128'(tensor_read_bank_out), 128'd1);
        @(posedge clock_in); #1;
        tb_banks[1] = {16{8'h55}};
        check("store_waddr0", 128'(cpu_write_address_out), 128'h40);
        check("store_wdata0", 128'(cpu_write_data_out), 128'hA0);
        wait_done(2, n);
        check("store_latency", 128'(n), 128'd18);
        check("store_stall_cycles", 128'(stall_count), 128'd17);
        check("store_write_count", 128'(cpu_wr_count), 128'd16);
        for (int i = 0; i < 16; i++) check($sformatf("store_mem%0d", i), 128'(cpu_wr_mem[8'h40 + i]), 128'(8'hA0 + i));
        @(posedge clock_in); #1;
        check("store_idle_stall", 128'(stall_out), 128'd0);

        // LOAD with wrap from 0xF8, start held high throughout and into DONE
        for (int i = 0; i < 16; i++) cpu_regs[8'(248 + i)] = 8'(8'h30 + i);
        clear_counters();
        @(negedge clock_in);
        start_in = 1'b1; op_in = 1'b0; cpu_base_address_in = 8'hF8; tensor_bank_in = 2'd3;
        @(posedge clock_in); #1;
        op_in = 1'b1; cpu_base_address_in = 8'h00; tensor_bank_in = 2'd0;
        check("wrap_raddr0", 128'(cpu_read_address_out), 128'hF8);
        wait_done(1, n);
        check("wrap_latency", 128'(n), 128'd17);
        @(posedge clock_in); #1; start_in = 1'b0;
        check("wrap_start_in_done_ignored", 128'(busy_out), 128'd0);
        repeat (5) @(posedge clock_in);
        #1;
        check("wrap_done_count", 128'(done_count), 128'd1);
        check("wrap_write_count", 128'(tensor_wr_count), 128'd16);
        check("wrap_no_store", 128'(stall_count), 128'd0);
        check("wrap_raddr7", 128'(rd_log[7]), 128'hFF);
        check("wrap_raddr8", 128'(rd_log[8]), 128'h00);
        for (int i = 0; i < 16; i++) check($sformatf("wrap_mem%0d", i), 128'(tensor_mem[48 + i]), 128'(8'h30 + i));
        @(negedge clock_in);
        start_in = 1'b1; op_in = 1'b0; cpu_base_address_in = 8'h00; tensor_bank_in = 2'd0;
        @(posedge clock_in); #1; start_in = 1'b0;
        check("restart_accepted", 128'(busy_out), 128'd1);
        wait_done(1, n);
        check("restart_latency", 128'(n), 128'd17);
        @(posedge clock_in); #1;

        // Reset in the middle of STORE at k=5
        clear_counters();
        @(negedge clock_in);
        start_in = 1'b1; op_in = 1'b1; cpu_base_address_in = 8'h80; tensor_bank_in = 2'd0;
        @(posedge clock_in); #1; start_in = 1'b0;
        repeat (6) @(posedge clock_in);
        #1;
        check("abort_k5_addr", 128'(cpu_write_address_out), 128'h85);
        #2; reset_n_in = 1'b0; #1;
        check("abort_outputs", 128'(all_outs), 128'd0);
        check("abort_write_count", 128'(cpu_wr_count), 128'd5);
        repeat (3) @(posedge clock_in);
        #1;
        check("abort_no_done", 128'(done_count), 128'd0);
        @(negedge clock_in); reset_n_in = 1'b1;
        @(posedge clock_in); #1;
        check("abort_stays_idle", 128'(busy_out), 128'd0);
        check("abort_final_writes", 128'(cpu_wr_count), 128'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tensor_transfer_controller.md
TENSOR_TRANSFER_CONTROLLER -- requirements
Module: tensor_transfer_controller

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, element width; NUMBER_OF_BANKS, default 4, tensor banks of 16 elements each.
REQ-002 SHALL have ports:
- clock_in  input  1  sole clock, rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request pulse, sampled only in IDLE.
- op_in  input  1  0 = LOAD (CPU regs to tensor bank), 1 = STORE (tensor bank to CPU regs).
- cpu_base_address_in  input  8  first CPU register.
- tensor_bank_in  input  2  target tensor bank.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle completion pulse.
- stall_out  output  1  CPU must not write its register file.
- cpu_read_address_out  output  8  CPU register-file read address.
- cpu_read_data_in  input  8  combinational read data for cpu_read_address_out.
- cpu_write_enable_out  output  1  CPU register-file write strobe.
- cpu_write_address_out  output  8  CPU register-file write address.
- cpu_write_data_out  output  8  CPU register-file write data.
- tensor_write_enable_out  output  1  tensor register-file write strobe.
- tensor_write_address_out  output  6  {bank, element index}.
- tensor_write_data_out  output  8  tensor write data.
- tensor_read_bank_out  output  2  bank presented to the tensor read port.
- tensor_read_data_in  input  128  4x4 matrix; element k at bits [8k+7:8k].

Function
REQ-003 SHALL implement states IDLE, LOAD, CAPTURE, STORE, DONE.
REQ-004 IDLE with start_in=1 SHALL latch op, base and bank; go to LOAD (op 0) or CAPTURE (op 1); clear element counter k to 0.
REQ-005 start_in outside IDLE SHALL be ignored; no queuing.
REQ-006 LOAD cycle k: cpu_read_address_out = base+k mod 256; tensor_write_enable_out=1; address {bank,k}; data = cpu_read_data_in.
REQ-007 LOAD SHALL last exactly 16 cycles (k = 0..15), then go to DONE.
REQ-008 CAPTURE SHALL last one cycle, drive tensor_read_bank_out = bank and register tensor_read_data_in into a 128-bit snapshot, then go to STORE.
REQ-009 STORE cycle k: cpu_write_enable_out=1; cpu_write_address_out = base+k mod 256; data = snapshot element k (row k[3:2], column k[1:0]); 16 cycles, then go to DONE.
REQ-010 stall_out SHALL be 1 in CAPTURE and STORE only.
REQ-011 DONE SHALL last one cycle with done_out=1, then return to IDLE.
REQ-012 Latency from the start_in sample edge to done_out high: LOAD 17 cycles, STORE 18 cycles.
REQ-013 Address wrap SHALL be modulo 256; base 0xF8 covers registers 0xF8..0xFF, then 0x00..0x07.
REQ-014 All write enables SHALL be 0 in IDLE, CAPTURE and DONE.
REQ-015 tensor_read_bank_out SHALL hold the latched bank outside IDLE; in IDLE it SHALL be 0.

Reset
REQ-016 reset_n_in low SHALL immediately force state IDLE, k=0, snapshot=0 and every output to 0, without waiting for a clock edge.
REQ-017 Reset mid-transfer SHALL abort; elements already written stay written; no done_out is issued.

Structure
REQ-018 Shared package tensor_transfer_pkg SHALL hold the state enum, the op enum (OP_LOAD=0, OP_STORE=1) and constants MATRIX_DIM=4, ELEMENTS_PER_BANK=16.
REQ-019 Sub-module transfer_address_generator SHALL produce the CPU address (base+k) and the tensor address ({bank,k}) from the latched base, latched bank and k.

Verification
REQ-020 LOAD, base 0x10, bank 2, CPU regs 0x10..0x1F = 1..16 -> tensor writes at addresses 32..47 with data 1..16; done_out at cycle 17.
REQ-021 STORE, bank 1 matrix with element k = 0xA0+k, base 0x40 -> CPU writes 0x40..0x4F = 0xA0..0xAF; stall_out high for 17 cycles; done_out at cycle 18.
REQ-022 LOAD with base 0xF8 -> reads 0xF8..0xFF, then 0x00..0x07.
REQ-023 start_in pulsed every cycle during a LOAD -> exactly one transfer; the next start_in is accepted only in IDLE after DONE.
REQ-024 reset_n_in low at STORE k=5 -> all outputs 0 asynchronously; exactly 5 CPU writes observed; no done_out.
REQ-025 tensor_read_data_in changed after CAPTURE -> stored values equal the captured snapshot.
